// File: rtl/packet_drop_gate.sv
// Holds each packet in a beat FIFO until its drop decision arrives, then forwards or discards it.
// Also keeps the pass/drop statistics counters for the register block.
module packet_drop_gate #(
   parameter int C_AXIS_DATA_WIDTH    = 256,
   parameter int C_AXIS_TUSER_WIDTH   = 128,
   parameter int DATA_FIFO_DEPTH_BITS = 4,
   parameter int DEC_FIFO_DEPTH_BITS  = 2
) (
   input  logic                              AXI_ACLK,
   input  logic                              reset,
   input  logic [C_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
   input  logic                              S_AXIS_TVALID,
   output logic                              S_AXIS_TREADY,
   input  logic                              S_AXIS_TLAST,
   output logic [C_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
   output logic [C_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
   output logic                              M_AXIS_TVALID,
   input  logic                              M_AXIS_TREADY,
   output logic                              M_AXIS_TLAST,
   input  logic                              dec_valid,
   input  logic [4:0]                        dec_flags,
   output logic                              dec_ready,
   input  logic                              stat_clear,
   output logic [31:0]                       pass_count,
   output logic [31:0]                       drop_count,
   output logic [31:0]                       cksum_drop_count,
   output logic [31:0]                       mac_drop_count
);

   localparam int STRB_W     = C_AXIS_DATA_WIDTH / 8;
   localparam int BEAT_W     = 1 + C_AXIS_TUSER_WIDTH + STRB_W + C_AXIS_DATA_WIDTH;
   localparam int BEAT_DEPTH = 1 << DATA_FIFO_DEPTH_BITS;
   localparam int DEC_DEPTH  = 1 << DEC_FIFO_DEPTH_BITS;

   localparam logic [DATA_FIFO_DEPTH_BITS-1:0] BEAT_PTR_ONE  = DATA_FIFO_DEPTH_BITS'(1);
   localparam logic [DATA_FIFO_DEPTH_BITS:0]   BEAT_CNT_ONE  = (DATA_FIFO_DEPTH_BITS+1)'(1);
   localparam logic [DATA_FIFO_DEPTH_BITS:0]   BEAT_CNT_FULL = (DATA_FIFO_DEPTH_BITS+1)'(BEAT_DEPTH);
   localparam logic [DEC_FIFO_DEPTH_BITS-1:0]  DEC_PTR_ONE   = DEC_FIFO_DEPTH_BITS'(1);
   localparam logic [DEC_FIFO_DEPTH_BITS:0]    DEC_CNT_ONE   = (DEC_FIFO_DEPTH_BITS+1)'(1);
   localparam logic [DEC_FIFO_DEPTH_BITS:0]    DEC_CNT_FULL  = (DEC_FIFO_DEPTH_BITS+1)'(DEC_DEPTH);

   typedef enum logic [1:0] {
      WAIT_DEC,
      PASS,
      DROP
   } state_t;

   state_t state, next_state;

   logic [BEAT_W-1:0]               beat_mem [BEAT_DEPTH];
   logic [DATA_FIFO_DEPTH_BITS-1:0] beat_wr_ptr, beat_rd_ptr;
   logic [DATA_FIFO_DEPTH_BITS:0]   beat_count;
   logic                            beat_push, beat_pop, beat_empty;
   logic [BEAT_W-1:0]               beat_head;
   logic                            head_last;

   logic [4:0]                      dec_mem [DEC_DEPTH];
   logic [DEC_FIFO_DEPTH_BITS-1:0]  dec_wr_ptr, dec_rd_ptr;
   logic [DEC_FIFO_DEPTH_BITS:0]    dec_count;
   logic                            dec_push, dec_pop, dec_empty;
   logic [4:0]                      dec_head;

   logic                            pass_evt, drop_evt;

   assign S_AXIS_TREADY = (beat_count != BEAT_CNT_FULL);
   assign beat_empty    = (beat_count == '0);
   assign beat_push     = S_AXIS_TVALID & S_AXIS_TREADY;
   assign beat_head     = beat_mem[beat_rd_ptr];
   assign head_last     = beat_head[BEAT_W-1];

   assign M_AXIS_TLAST  = head_last;
   assign M_AXIS_TUSER  = beat_head[BEAT_W-2 -: C_AXIS_TUSER_WIDTH];
   assign M_AXIS_TSTRB  = beat_head[C_AXIS_DATA_WIDTH +: STRB_W];
   assign M_AXIS_TDATA  = beat_head[C_AXIS_DATA_WIDTH-1:0];

   assign dec_ready     = (dec_count != DEC_CNT_FULL);
   assign dec_empty     = (dec_count == '0);
   assign dec_push      = dec_valid & dec_ready;
   assign dec_head      = dec_mem[dec_rd_ptr];

   // Storage is written only from a non-full FIFO, so the head entry never changes under a stalled output.
   always_ff @(posedge AXI_ACLK) begin
      if (beat_push) begin
         beat_mem[beat_wr_ptr] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
      end
      if (dec_push) begin
         dec_mem[dec_wr_ptr] <= dec_flags;
      end
   end

   always_ff @(posedge AXI_ACLK) begin
      if (reset) begin
         beat_wr_ptr <= '0;
         beat_rd_ptr <= '0;
         beat_count  <= '0;
      end else begin
         if (beat_push) beat_wr_ptr <= beat_wr_ptr + BEAT_PTR_ONE;
         if (beat_pop)  beat_rd_ptr <= beat_rd_ptr + BEAT_PTR_ONE;
         case ({beat_push, beat_pop})
            2'b10:   beat_count <= beat_count + BEAT_CNT_ONE;
            2'b01:   beat_count <= beat_count - BEAT_CNT_ONE;
            default: beat_count <= beat_count;
         endcase
      end
   end

   always_ff @(posedge AXI_ACLK) begin
      if (reset) begin
         dec_wr_ptr <= '0;
         dec_rd_ptr <= '0;
         dec_count  <= '0;
      end else begin
         if (dec_push) dec_wr_ptr <= dec_wr_ptr + DEC_PTR_ONE;
         if (dec_pop)  dec_rd_ptr <= dec_rd_ptr + DEC_PTR_ONE;
         case ({dec_push, dec_pop})
            2'b10:   dec_count <= dec_count + DEC_CNT_ONE;
            2'b01:   dec_count <= dec_count - DEC_CNT_ONE;
            default: dec_count <= dec_count;
         endcase
      end
   end

   always_ff @(posedge AXI_ACLK) begin
      if (reset) begin
         state <= WAIT_DEC;
      end else begin
         state <= next_state;
      end
   end

   // The decision stays at the FIFO head for the whole packet and is retired with its TLAST beat.
   always_comb begin
      next_state    = state;
      M_AXIS_TVALID = 1'b0;
      beat_pop      = 1'b0;
      dec_pop       = 1'b0;
      pass_evt      = 1'b0;
      drop_evt      = 1'b0;
      case (state)
         WAIT_DEC: begin
            if (!dec_empty) begin
               next_state = (dec_head == 5'd0) ? PASS : DROP;
            end
         end
         PASS: begin
            M_AXIS_TVALID = !beat_empty;
            beat_pop      = !beat_empty && M_AXIS_TREADY;
            if (beat_pop && head_last) begin
               dec_pop    = 1'b1;
               pass_evt   = 1'b1;
               next_state = WAIT_DEC;
            end
         end
         DROP: begin
            beat_pop = !beat_empty;
            if (beat_pop && head_last) begin
               dec_pop    = 1'b1;
               drop_evt   = 1'b1;
               next_state = WAIT_DEC;
            end
         end
         default: next_state = WAIT_DEC;
      endcase
   end

   always_ff @(posedge AXI_ACLK) begin
      if (reset || stat_clear) begin
         pass_count       <= '0;
         drop_count       <= '0;
         cksum_drop_count <= '0;
         mac_drop_count   <= '0;
      end else begin
         if (pass_evt) pass_count <= pass_count + 32'd1;
         if (drop_evt) begin
            drop_count <= drop_count + 32'd1;
            if (dec_head[0])      cksum_drop_count <= cksum_drop_count + 32'd1;
            if (|dec_head[4:1])   mac_drop_count   <= mac_drop_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_packet_drop_gate.sv
// Scoreboard bench for packet_drop_gate: passed beats are queued when driven and matched at the output.
module tb_packet_drop_gate;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int SW = DW / 8;
   localparam int BW = 1 + UW + SW + DW;

   logic           AXI_ACLK = 1'b0;
   logic           reset;
   logic [DW-1:0]  S_AXIS_TDATA;
   logic [SW-1:0]  S_AXIS_TSTRB;
   logic [UW-1:0]  S_AXIS_TUSER;
   logic           S_AXIS_TVALID;
   logic           S_AXIS_TREADY;
   logic           S_AXIS_TLAST;
   logic [DW-1:0]  M_AXIS_TDATA;
   logic [SW-1:0]  M_AXIS_TSTRB;
   logic [UW-1:0]  M_AXIS_TUSER;
   logic           M_AXIS_TVALID;
   logic           M_AXIS_TREADY;
   logic           M_AXIS_TLAST;
   logic           dec_valid;
   logic [4:0]     dec_flags;
   logic           dec_ready;
   logic           stat_clear;
   logic [31:0]    pass_count, drop_count, cksum_drop_count, mac_drop_count;

   int             checks = 0;
   int             errors = 0;
   logic [BW-1:0]  exp_q[$];
   int             exp_pass, exp_drop, exp_cksum, exp_mac;
   int             accepted_beats;
   logic           bp_en = 1'b0;
   logic [3:0]     bp_pat = 4'b1001;
   int             bp_phase;
   logic           held = 1'b0;
   logic [BW-1:0]  held_beat;

   always #5 AXI_ACLK = ~AXI_ACLK;

   packet_drop_gate dut (
      .AXI_ACLK         (AXI_ACLK),
      .reset            (reset),
      .S_AXIS_TDATA     (S_AXIS_TDATA),
      .S_AXIS_TSTRB     (S_AXIS_TSTRB),
      .S_AXIS_TUSER     (S_AXIS_TUSER),
      .S_AXIS_TVALID    (S_AXIS_TVALID),
      .S_AXIS_TREADY    (S_AXIS_TREADY),
      .S_AXIS_TLAST     (S_AXIS_TLAST),
      .M_AXIS_TDATA     (M_AXIS_TDATA),
      .M_AXIS_TSTRB     (M_AXIS_TSTRB),
      .M_AXIS_TUSER     (M_AXIS_TUSER),
      .M_AXIS_TVALID    (M_AXIS_TVALID),
      .M_AXIS_TREADY    (M_AXIS_TREADY),
      .M_AXIS_TLAST     (M_AXIS_TLAST),
      .dec_valid        (dec_valid),
      .dec_flags        (dec_flags),
      .dec_ready        (dec_ready),
      .stat_clear       (stat_clear),
      .pass_count       (pass_count),
      .drop_count       (drop_count),
      .cksum_drop_count (cksum_drop_count),
      .mac_drop_count   (mac_drop_count)
   );

   task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_pass"},  512'(pass_count),       512'(exp_pass));
      checkOutput({tag, "_drop"},  512'(drop_count),       512'(exp_drop));
      checkOutput({tag, "_cksum"}, 512'(cksum_drop_count), 512'(exp_cksum));
      checkOutput({tag, "_mac"},   512'(mac_drop_count),   512'(exp_mac));
   endtask

   // Drives one packet of random beats; beats of a packet that will pass are queued as expected output.
   task automatic applyStimulus(input int nbeats, input logic [4:0] flags);
      logic [DW-1:0] d;
      logic [UW-1:0] u;
      logic [SW-1:0] s;
      logic          l;
      bit            acc;
      int            waitc;
      for (int i = 0; i < nbeats; i++) begin
         for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
         for (int k = 0; k < UW/32; k++) u[k*32 +: 32] = $urandom;
         s = $urandom;
         l = (i == nbeats - 1);
         S_AXIS_TDATA  = d;
         S_AXIS_TUSER  = u;
         S_AXIS_TSTRB  = s;
         S_AXIS_TLAST  = l;
         S_AXIS_TVALID = 1'b1;
         acc   = 1'b0;
         waitc = 0;
         while (!acc && waitc < 200) begin
            acc = S_AXIS_TREADY;
            @(posedge AXI_ACLK); #1;
            waitc++;
         end
         if (!acc) begin
            checkOutput("s_ready_timeout", 512'(S_AXIS_TREADY), 512'(1));
         end else begin
            accepted_beats++;
            if (flags == 5'd0) exp_q.push_back({l, u, s, d});
         end
      end
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
   endtask

   task automatic applyDecision(input logic [4:0] flags);
      bit acc;
      int waitc;
      dec_valid = 1'b1;
      dec_flags = flags;
      acc   = 1'b0;
      waitc = 0;
      while (!acc && waitc < 200) begin
         acc = dec_ready;
         @(posedge AXI_ACLK); #1;
         waitc++;
      end
      dec_valid = 1'b0;
      if (!acc) begin
         checkOutput("dec_ready_timeout", 512'(dec_ready), 512'(1));
      end else if (flags == 5'd0) begin
         exp_pass++;
      end else begin
         exp_drop++;
         if (flags[0])    exp_cksum++;
         if (|flags[4:1]) exp_mac++;
      end
   endtask

   task automatic waitDrain();
      int c = 0;
      while (exp_q.size() != 0 && c < 400) begin
         @(posedge AXI_ACLK); #1;
         c++;
      end
      checkOutput("drain_timeout", 512'(exp_q.size()), 512'(0));
      repeat (30) @(posedge AXI_ACLK);
      #1;
   endtask

   // Output monitor: matches transferred beats against the scoreboard and checks stalled beats hold.
   always @(negedge AXI_ACLK) begin
      logic [BW-1:0] cur;
      cur = {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA};
      if (reset) begin
         held = 1'b0;
      end else begin
         if (held) begin
            checkOutput("hold_valid", 512'(M_AXIS_TVALID), 512'(1));
            checkOutput("hold_beat", 512'(cur), 512'(held_beat));
         end
         held      = M_AXIS_TVALID && !M_AXIS_TREADY;
         held_beat = cur;
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (exp_q.size() == 0) checkOutput("unexpected_beat_qsize", 512'(exp_q.size()), 512'(1));
            else                   checkOutput("beat", 512'(cur), 512'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      M_AXIS_TREADY = 1'b1;
      bp_phase = 0;
      forever begin
         @(posedge AXI_ACLK); #1;
         if (bp_en) begin
            M_AXIS_TREADY = bp_pat[bp_phase];
            bp_phase = (bp_phase + 1) % 4;
         end else begin
            M_AXIS_TREADY = 1'b1;
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [4:0] f5 [5];
      bit         found;
      f5 = '{5'd0, 5'd2, 5'd0, 5'd1, 5'h10};
      reset = 1'b1; stat_clear = 1'b0;
      S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
      S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0; S_AXIS_TUSER = '0;
      dec_valid = 1'b0; dec_flags = '0;
      exp_pass = 0; exp_drop = 0; exp_cksum = 0; exp_mac = 0; accepted_beats = 0;
      repeat (3) @(posedge AXI_ACLK);
      #1 reset = 1'b0;
      checkOutput("rst_m_valid", 512'(M_AXIS_TVALID), 512'(0));
      checkOutput("rst_s_ready", 512'(S_AXIS_TREADY), 512'(1));
      checkOutput("rst_dec_ready", 512'(dec_ready), 512'(1));
      checkCounters("rst");

      $display("[TB] 3-beat pass packet");
      fork
         applyStimulus(3, 5'd0);
         applyDecision(5'd0);
      join
      waitDrain();
      checkCounters("t1");

      $display("[TB] drop then pass");
      fork
         begin applyStimulus(2, 5'd1); applyStimulus(2, 5'd0); end
         begin applyDecision(5'd1); applyDecision(5'd0); end
      join
      waitDrain();
      checkCounters("t2");

      $display("[TB] long packets with late decision");
      for (int v = 0; v < 2; v++) begin
         logic [4:0] fl;
         fl = (v == 0) ? 5'd0 : 5'b00100;
         accepted_beats = 0;
         fork
            applyStimulus(20, fl);
            begin
               repeat (30) @(posedge AXI_ACLK);
               #1;
               checkOutput("full_s_ready", 512'(S_AXIS_TREADY), 512'(0));
               checkOutput("full_beats", 512'(accepted_beats), 512'(16));
               applyDecision(fl);
            end
         join
         waitDrain();
         checkCounters("t3");
      end

      $display("[TB] output backpressure");
      bp_phase = 0;
      bp_en = 1'b1;
      fork
         applyStimulus(6, 5'd0);
         applyDecision(5'd0);
      join
      waitDrain();
      bp_en = 1'b0;
      checkCounters("t4");

      $display("[TB] decisions queued ahead");
      for (int i = 0; i < 4; i++) applyDecision(f5[i]);
      checkOutput("dec_full", 512'(dec_ready), 512'(0));
      fork
         for (int i = 0; i < 5; i++) applyStimulus(2, f5[i]);
         applyDecision(f5[4]);
         begin
            @(posedge AXI_ACLK); #1;
            checkOutput("dec_full_hold", 512'(dec_ready), 512'(0));
         end
      join
      waitDrain();
      checkCounters("t5");

      $display("[TB] reset mid-packet");
      S_AXIS_TDATA = {8{32'hA5A5_0001}}; S_AXIS_TUSER = '0; S_AXIS_TSTRB = '1;
      S_AXIS_TLAST = 1'b0; S_AXIS_TVALID = 1'b1;
      dec_valid = 1'b1; dec_flags = 5'd1;
      @(posedge AXI_ACLK); #1;
      dec_valid = 1'b0;
      S_AXIS_TDATA = {8{32'hA5A5_0002}};
      reset = 1'b1;
      @(posedge AXI_ACLK); #1;
      reset = 1'b0;
      S_AXIS_TVALID = 1'b0;
      exp_pass = 0; exp_drop = 0; exp_cksum = 0; exp_mac = 0;
      exp_q.delete();
      checkOutput("t6_m_valid", 512'(M_AXIS_TVALID), 512'(0));
      checkCounters("t6_rst");
      fork
         applyStimulus(1, 5'd0);
         applyDecision(5'd0);
      join
      waitDrain();
      checkCounters("t6");

      $display("[TB] stat_clear against pass TLAST");
      for (int i = 0; i < 6; i++) begin
         fork
            applyStimulus(1, 5'd0);
            applyDecision(5'd0);
         join
      end
      waitDrain();
      checkCounters("t7_pre");
      fork
         applyStimulus(1, 5'd0);
         applyDecision(5'd0);
      join
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (M_AXIS_TVALID && M_AXIS_TLAST && M_AXIS_TREADY) begin
            stat_clear = 1'b1;
            @(posedge AXI_ACLK); #1;
            stat_clear = 1'b0;
            found = 1'b1;
         end else begin
            @(posedge AXI_ACLK); #1;
         end
      end
      checkOutput("t7_tlast_seen", 512'(found), 512'(1));
      exp_pass = 0; exp_drop = 0; exp_cksum = 0; exp_mac = 0;
      checkOutput("t7_clear_pass", 512'(pass_count), 512'(0));
      waitDrain();
      checkCounters("t7_post");
      fork
         applyStimulus(2, 5'd0);
         applyDecision(5'd0);
      join
      waitDrain();
      checkCounters("t7_resume");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/packet_drop_gate.md
Name: packet_drop_gate

Overview:
- Downstream stage of the MAC/checksum validation stage in the router output-port-lookup pipeline.
- Receives the AXI4-Stream packet flow plus one 5-bit drop-reason word per packet, and buffers each packet until its decision is available.
- Forwards the whole packet when the word is zero; otherwise silently discards every beat.
- Maintains pass/drop statistics counters for the register block.

Parameters:
- C_AXIS_DATA_WIDTH, 256, TDATA width; TSTRB is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, TUSER width, passed through untouched.
- DATA_FIFO_DEPTH_BITS, 4, log2 depth of the beat FIFO (16 beats).
- DEC_FIFO_DEPTH_BITS, 2, log2 depth of the decision FIFO (4 packets).

Ports:
- AXI_ACLK  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- S_AXIS_TDATA  in  C_AXIS_DATA_WIDTH  input beat data.
- S_AXIS_TSTRB  in  C_AXIS_DATA_WIDTH/8  input byte strobes.
- S_AXIS_TUSER  in  C_AXIS_TUSER_WIDTH  input metadata.
- S_AXIS_TVALID  in  1  input beat valid.
- S_AXIS_TREADY  out  1  high when beat FIFO is not full.
- S_AXIS_TLAST  in  1  last beat of packet.
- M_AXIS_TDATA  out  C_AXIS_DATA_WIDTH  output beat data.
- M_AXIS_TSTRB  out  C_AXIS_DATA_WIDTH/8  output strobes.
- M_AXIS_TUSER  out  C_AXIS_TUSER_WIDTH  output metadata.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  last output beat.
- dec_valid  in  1  drop decision for the oldest undecided packet.
- dec_flags  in  5  bit0 = bad checksum; bits4:1 = wrong MAC on ports 0..3.
- dec_ready  out  1  high when decision FIFO is not full.
- stat_clear  in  1  synchronous clear of all counters.
- pass_count  out  32  packets forwarded.
- drop_count  out  32  packets discarded.
- cksum_drop_count  out  32  dropped packets with dec_flags[0] set.
- mac_drop_count  out  32  dropped packets with any of dec_flags[4:1] set.

Behaviour:
- Reset (reset=1 at a clock edge):
  - Both FIFOs flushed; state = WAIT_DEC; all counters = 0.
  - M_AXIS_TVALID = 0; S_AXIS_TREADY and dec_ready = 1 from the following cycle.
  - Reset mid-packet discards all buffered beats and decisions. The first beat accepted after reset is treated as a packet start.
- Beat FIFO write: S_AXIS_TVALID & S_AXIS_TREADY stores {TLAST, TUSER, TSTRB, TDATA}.
- Decision FIFO write: dec_valid & dec_ready stores dec_flags.
- Decisions map to packets strictly in arrival order. A decision arriving before, during or after its packet is legal.
- FSM:
  - WAIT_DEC:
    - M_AXIS_TVALID = 0; no beat pops.
    - If the decision FIFO is non-empty, go to PASS when head flags = 0, else go to DROP, on the next edge.
    - The decision is not popped on this transition.
  - PASS:
    - M_AXIS_TVALID = beat FIFO non-empty; M_AXIS_* = FIFO head.
    - A beat pops on TVALID & TREADY.
    - On the pop of the TLAST beat: pop the decision, pass_count += 1, return to WAIT_DEC.
  - DROP:
    - M_AXIS_TVALID = 0.
    - Pop one beat per cycle whenever the beat FIFO is non-empty, regardless of M_AXIS_TREADY.
    - On the TLAST pop: pop the decision; drop_count += 1; cksum_drop_count += 1 if flags[0]; mac_drop_count += 1 if flags[4:1] != 0 (both may increment for one packet); return to WAIT_DEC.
- Output stability: M_AXIS_TDATA/TSTRB/TUSER/TLAST are stable while TVALID=1 and TREADY=0.
- Latency: minimum 1 idle cycle per packet (the WAIT_DEC evaluation). When a beat and its decision are written on the same edge N, the first beat presents on M_AXIS by the cycle after edge N+1.
- Beat FIFO full: S_AXIS_TREADY = 0; upstream holds.
  - A packet longer than the beat FIFO whose decision is late must not deadlock. WAIT_DEC is left as soon as the decision arrives, and the FIFO then drains.
- Decision FIFO full: dec_ready = 0; upstream holds.
- Simultaneous FIFO write and pop in the same cycle is legal at any occupancy, including full and empty.
- Counters:
  - 32-bit unsigned; wrap 0xFFFFFFFF -> 0.
  - stat_clear has priority over a same-cycle increment (result 0; the event is not counted).
  - stat_clear does not affect data flow or the FSM.

Test Plan:
- 3-beat packet with flags=0, decision given with beat 1, TREADY=1 -> 3 beats out in order, TLAST on beat 3, pass_count=1, drop_count=0.
- 2-beat packet with flags=5'b00001, then 2-beat packet with flags=0 -> only the second packet appears on M_AXIS; drop_count=1, cksum_drop_count=1, pass_count=1.
- 20-beat packet with its decision held off until 30 cycles after the first beat -> S_AXIS_TREADY=0 after 16 beats; on decision flags=0 all 20 beats emerge intact; with flags=5'b00100 no beats emerge, mac_drop_count=1.
- Output backpressure: TREADY toggles 1,0,0,1 during a passed packet -> M_AXIS data held stable while TREADY=0; no beat lost or duplicated.
- 4 decisions queued ahead of packets -> dec_ready=0 until the first packet's TLAST pops; decisions apply in order.
- reset asserted on the 2nd beat of a 4-beat packet -> TVALID=0 and counters=0 the next cycle; a subsequent 1-beat packet with flags=0 passes and pass_count=1.
- stat_clear asserted in the same cycle as a pass TLAST pop with pass_count=7 -> pass_count=0.
